key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Front-end for the 7 raw push-buttons. Synchronises, debounces and edge-detects each key.
//  Produces clean levels plus one-cycle press, release and long-press pulses.
//  Sits between the keys pins and every consumer: control, utility/picture/gif.
//  Consumers use its pulses instead of sampling keys directly.
// PARAMETERS
//  N_KEYS          7           number of keys
//  CLK_HZ          50_000_000  clock frequency; a 1 ms tick = CLK_HZ/1000 cycles
//  DEBOUNCE_MS     20          stable time required to accept a change (>=1)
//  LONG_MS         600         hold time, measured from key_level rising, to fire key_long (>DEBOUNCE_MS)
//  REPEAT_MS       150         auto-repeat period after key_long (>=1)
//  KEY_ACTIVE_LOW  1           1: raw pin low = pressed
// PORTS
//  CLOCK_50     in   1       system clock, all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  keys         in   N_KEYS  raw asynchronous button pins
//  key_level    out  N_KEYS  debounced state, 1 = pressed
//  key_press    out  N_KEYS  1-cycle pulse on debounced press
//  key_release  out  N_KEYS  1-cycle pulse on debounced release
//  key_long     out  N_KEYS  1-cycle pulse when hold reaches LONG_MS
//  key_repeat   out  N_KEYS  1-cycle auto-repeat pulses (see CONFIGURATION)
//  any_key      out  1       OR of key_level
// BEHAVIOUR
//  - Reset: all outputs 0.
//    - Sync flops and stable states are loaded with "released".
//    - Prescaler and all counters are cleared.
//  - Reset mid-press: a still-held key must complete a full debounce, then emit a fresh key_press.
//  - Sync: 2-flop synchroniser per key, then polarity normalise (pressed=1). Adds 2 cycles latency.
//  - Tick: shared prescaler, 0..CLK_HZ/1000-1. tick=1 for one cycle at terminal count, then wraps to 0.
//  - Debounce: per-key counter db_cnt, width $clog2(DEBOUNCE_MS+1).
//    - sample==key_level: db_cnt<=0 on that cycle (any glitch restarts).
//    - sample!=key_level and tick: db_cnt+1.
//    - db_cnt reaching DEBOUNCE_MS: key_level toggles on that cycle; db_cnt<=0.
//  - Edge pulses: key_press/key_release are registered.
//    - Each is high exactly the cycle key_level reads its new value.
//    - Never both high for one key.
//  - Hold FSM, per key:
//    - IDLE -> HOLD on press; hold_cnt<=0.
//    - HOLD: hold_cnt+1 per tick. At LONG_MS: key_long pulse, -> LONGHELD; hold_cnt<=0.
//    - LONGHELD: counts ticks. At REPEAT_MS: key_repeat pulse, hold_cnt<=0, wraps.
//    - Any state -> IDLE on release. Release takes priority over a same-cycle long/repeat event; no pulse.
//    - hold_cnt width $clog2(max(LONG_MS,REPEAT_MS)+1); never overflows.
//  - Keys are fully independent. Simultaneous events on several keys give same-cycle pulses.
//  - any_key is combinational OR of registered key_level.
// CONFIGURATION
//  - KEY_REPEAT_EN defined: LONGHELD repeat counting and key_repeat as above.
//  - KEY_REPEAT_EN undefined:
//    - key_repeat tied to 0.
//    - LONGHELD waits for release, no counting.
//    - key_long still fires once per hold.
// TESTING  (bench params: CLK_HZ=1000 so tick every cycle, DEBOUNCE_MS=4, LONG_MS=10, REPEAT_MS=3)
//  1. rst 3 cycles, keys=7'h7F
//     -> all outputs 0, any_key=0; stay 0 for 50 cycles.
//  2. keys[0]=0 held
//     -> key_level[0]=1 and 1-cycle key_press[0] 6 cycles after the edge.
//     keys[0] low for 3 cycles only -> no output change.
//  3. keys[2] toggling every 2 cycles for 20 cycles, then low
//     -> exactly one key_press[2], 6 cycles after the final edge.
//  4. keys[1] held 40 cycles with KEY_REPEAT_EN
//     -> key_long[1] 10 cycles after key_press[1]; key_repeat[1] every 3 cycles thereafter.
//     Then release -> one key_release[1], pulses stop.
//     Without macro: key_repeat stays 0.
//  5. keys[3] and keys[5] fall in the same cycle
//     -> key_press=7'h28 in one cycle, any_key=1.
//  6. rst pulsed 1 cycle while keys[4] held and key_level[4]=1
//     -> outputs 0 next cycle.
//     Then fresh key_press[4] 6 cycles after rst deasserts; no key_release[4].

Source files
------------

// File: rtl/key_conditioner.sv
// Purpose: synchronise, debounce and edge-detect the raw push-buttons; emit clean levels plus press/release/long/repeat pulses.
// Latency: 2-cycle synchroniser, then DEBOUNCE_MS ticks of stable input before key_level/key_press/key_release update (all registered).
// Backpressure: none; pulses are single-cycle and unbuffered. Optional macro KEY_REPEAT_EN enables auto-repeat in the long-held state.
module key_conditioner #(
  parameter int N_KEYS         = 7,
  parameter int CLK_HZ         = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int LONG_MS        = 600,
  parameter int REPEAT_MS      = 150,
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              any_key
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Cycles per 1 ms tick; clamp so a very slow clock still ticks every cycle.
  localparam int TICK_DIV = ((CLK_HZ / 1000) < 1) ? 1 : (CLK_HZ / 1000);
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Debounce counter only has to reach DEBOUNCE_MS.
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);

  // Hold counter sized for the longer of the two hold intervals.
  localparam int MAXH = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW   = $clog2(MAXH + 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_MS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_MS - 1);
`endif

  // Raw pin value that means "released"; also the synchroniser reset value.
  localparam logic POL = (KEY_ACTIVE_LOW != 0);
  localparam logic [N_KEYS-1:0] RAW_IDLE = {N_KEYS{POL}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_LONG = 2'd2
  } hold_st_t;

  // ---------------------------------------------------------------------------
  // Shared 1 ms prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PRESC_LAST);

  // Free-running prescaler: counts 0..TICK_DIV-1 and wraps on the tick cycle.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, then normalise so that 1 = pressed
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] sample;

  // Metastability guard for the asynchronous pins; reset loads "released".
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // XOR with the idle pattern flips active-low pins into pressed=1.
  assign sample = sync2 ^ RAW_IDLE;

  // ---------------------------------------------------------------------------
  // Per-key debounce, edge pulses and hold FSM
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [DW-1:0] db_cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          accept;
    logic          rise;
    logic          fall;

    hold_st_t      st;
    hold_st_t      st_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_cnt_nxt;
    logic          long_q;
    logic          long_nxt;

    // The debounced level flips on the cycle the stable count is reached.
    assign accept = (sample[k] != level_q) && tick && (db_cnt == DB_LAST);
    assign rise   = accept && !level_q;
    assign fall   = accept &&  level_q;

    // Debounce counter and debounced level; any agreeing sample restarts the count.
    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= rise;
        release_q <= fall;
        if (sample[k] == level_q) begin
          db_cnt <= '0;
        end else if (tick) begin
          if (accept) begin
            db_cnt  <= '0;
            level_q <= !level_q;
          end else begin
            db_cnt <= db_cnt + DW'(1);
          end
        end
      end
    end

    // Hold FSM state register plus its registered outputs and counter.
    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        st       <= S_IDLE;
        hold_cnt <= '0;
        long_q   <= 1'b0;
      end else begin
        st       <= st_nxt;
        hold_cnt <= hold_cnt_nxt;
        long_q   <= long_nxt;
      end
    end

    // Next-state: release always wins over a long/repeat event in the same cycle.
    always_comb begin
      st_nxt = st;
      case (st)
        S_IDLE: begin
          if (rise) begin
            st_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (fall) begin
            st_nxt = S_IDLE;
          end else if (tick && (hold_cnt == LONG_LAST)) begin
            st_nxt = S_LONG;
          end
        end
        S_LONG: begin
          if (fall) begin
            st_nxt = S_IDLE;
          end
        end
        default: begin
          st_nxt = S_IDLE;
        end
      endcase
    end

`ifdef KEY_REPEAT_EN
    logic rep_q;
    logic rep_nxt;

    // Repeat pulse register, only present when auto-repeat is built in.
    always_ff @(posedge CLOCK_50) begin
      if (rst) begin
        rep_q <= 1'b0;
      end else begin
        rep_q <= rep_nxt;
      end
    end

    // Outputs/counter: long pulse after LONG_MS ticks, then a repeat every REPEAT_MS ticks.
    always_comb begin
      long_nxt     = 1'b0;
      rep_nxt      = 1'b0;
      hold_cnt_nxt = hold_cnt;
      case (st)
        S_IDLE: begin
          hold_cnt_nxt = '0;
        end
        S_HOLD: begin
          if (fall) begin
            hold_cnt_nxt = '0;
          end else if (tick) begin
            if (hold_cnt == LONG_LAST) begin
              long_nxt     = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + HW'(1);
            end
          end
        end
        S_LONG: begin
          if (fall) begin
            hold_cnt_nxt = '0;
          end else if (tick) begin
            if (hold_cnt == REP_LAST) begin
              rep_nxt      = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + HW'(1);
            end
          end
        end
        default: begin
          hold_cnt_nxt = '0;
        end
      endcase
    end

    assign key_repeat[k] = rep_q;
`else
    // Outputs/counter: long pulse after LONG_MS ticks; the long-held state just waits for release.
    always_comb begin
      long_nxt     = 1'b0;
      hold_cnt_nxt = hold_cnt;
      case (st)
        S_IDLE: begin
          hold_cnt_nxt = '0;
        end
        S_HOLD: begin
          if (fall) begin
            hold_cnt_nxt = '0;
          end else if (tick) begin
            if (hold_cnt == LONG_LAST) begin
              long_nxt     = 1'b1;
              hold_cnt_nxt = '0;
            end else begin
              hold_cnt_nxt = hold_cnt + HW'(1);
            end
          end
        end
        S_LONG: begin
          hold_cnt_nxt = '0;
        end
        default: begin
          hold_cnt_nxt = '0;
        end
      endcase
    end

    assign key_repeat[k] = 1'b0;
`endif

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;
  end

  assign any_key = |key_level;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with a 1-cycle tick (CLK_HZ=1000).
// Expected pulses are queued when keys are driven and compared cycle by cycle.
// Level and any_key are checked at chosen points of each scenario.
module tb_key_conditioner;
  localparam int NK = 7;

  logic          CLOCK_50;
  logic          rst;
  logic [NK-1:0] keys;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic [NK-1:0] key_repeat;
  logic          any_key;

  key_conditioner #(
    .N_KEYS(NK),
    .CLK_HZ(1000),
    .DEBOUNCE_MS(4),
    .LONG_MS(10),
    .REPEAT_MS(3),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .keys(keys),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_long(key_long),
    .key_repeat(key_repeat),
    .any_key(any_key)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    int            cyc;
    logic [NK-1:0] p;
    logic [NK-1:0] r;
    logic [NK-1:0] l;
    logic [NK-1:0] rp;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_ev(input int at, input logic [NK-1:0] p, input logic [NK-1:0] r,
                         input logic [NK-1:0] l, input logic [NK-1:0] rp);
    ev_t e;
    e.cyc = at;
    e.p   = p;
    e.r   = r;
    e.l   = l;
    e.rp  = rp;
    exp_q.push_back(e);
  endtask

  // Compare this cycle's pulse outputs with the scoreboard head (or all-zero).
  task automatic monitor_cycle();
    ev_t             e;
    logic [4*NK-1:0] obs;
    logic [4*NK-1:0] expv;
    obs  = {key_press, key_release, key_long, key_repeat};
    expv = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missed_event", 64'(cyc), 64'(e.cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e    = exp_q.pop_front();
      expv = {e.p, e.r, e.l, e.rp};
    end
    chk("pulses{press,rel,long,rep}", 64'(obs), 64'(expv));
  endtask

  // Advance n clocks; inputs are driven at the falling edge after return.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      cyc++;
      @(negedge CLOCK_50);
      monitor_cycle();
    end
  endtask

  initial begin
    int c0;
    rst  = 1'b1;
    keys = 7'h7F;

    // 1. reset, then idle for 50 cycles
    run(3);
    chk("reset_level", 64'(key_level), 64'h0);
    chk("reset_any", 64'(any_key), 64'h0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      run(1);
      chk("idle_level", 64'(key_level), 64'h0);
      chk("idle_any", 64'(any_key), 64'h0);
    end

    // 2a. 3-cycle glitch on key 0 is rejected
    keys[0] = 1'b0;
    run(3);
    keys[0] = 1'b1;
    run(10);
    chk("glitch_level", 64'(key_level), 64'h0);

    // 2b. held key 0: press 6 cycles after the edge, then release
    keys[0] = 1'b0;
    push_ev(cyc + 6, 7'h01, 7'h00, 7'h00, 7'h00);
    run(5);
    chk("pre_press0_level", 64'(key_level), 64'h0);
    run(1);
    chk("press0_level", 64'(key_level), 64'h01);
    chk("press0_any", 64'(any_key), 64'h1);
    keys[0] = 1'b1;
    push_ev(cyc + 6, 7'h00, 7'h01, 7'h00, 7'h00);
    run(8);
    chk("rel0_level", 64'(key_level), 64'h0);

    // 3. key 2 bouncing every 2 cycles, then settling low
    for (int i = 0; i < 10; i++) begin
      keys[2] = ~keys[2];
      run(2);
    end
    chk("bounce_level", 64'(key_level), 64'h0);
    keys[2] = 1'b0;
    push_ev(cyc + 6, 7'h04, 7'h00, 7'h00, 7'h00);
    run(8);
    chk("bounce_press_level", 64'(key_level), 64'h04);
    keys[2] = 1'b1;
    push_ev(cyc + 6, 7'h00, 7'h04, 7'h00, 7'h00);
    run(8);

    // 4. key 1 held 40 cycles: long 10 after press, repeats every 3 (if built)
    keys[1] = 1'b0;
    c0 = cyc;
    push_ev(c0 + 6, 7'h02, 7'h00, 7'h00, 7'h00);
    push_ev(c0 + 16, 7'h00, 7'h00, 7'h02, 7'h00);
`ifdef KEY_REPEAT_EN
    for (int t = c0 + 19; t <= c0 + 43; t += 3) begin
      push_ev(t, 7'h00, 7'h00, 7'h00, 7'h02);
    end
`endif
    run(40);
    chk("long_hold_level", 64'(key_level), 64'h02);
    keys[1] = 1'b1;
    // release lands on a repeat boundary; release wins and no repeat fires
    push_ev(cyc + 6, 7'h00, 7'h02, 7'h00, 7'h00);
    run(12);
    chk("long_rel_level", 64'(key_level), 64'h0);

    // 5. keys 3 and 5 pressed together
    keys[3] = 1'b0;
    keys[5] = 1'b0;
    push_ev(cyc + 6, 7'h28, 7'h00, 7'h00, 7'h00);
    run(6);
    chk("dual_level", 64'(key_level), 64'h28);
    chk("dual_any", 64'(any_key), 64'h1);
    keys[3] = 1'b1;
    keys[5] = 1'b1;
    push_ev(cyc + 6, 7'h00, 7'h28, 7'h00, 7'h00);
    run(8);
    chk("dual_rel_any", 64'(any_key), 64'h0);

    // 6. reset while key 4 is held: fresh press, no release
    keys[4] = 1'b0;
    push_ev(cyc + 6, 7'h10, 7'h00, 7'h00, 7'h00);
    run(7);
    chk("pre_rst_level", 64'(key_level), 64'h10);
    rst = 1'b1;
    run(1);
    chk("midrst_level", 64'(key_level), 64'h0);
    chk("midrst_any", 64'(any_key), 64'h0);
    rst = 1'b0;
    push_ev(cyc + 6, 7'h10, 7'h00, 7'h00, 7'h00);
    run(5);
    chk("post_rst_wait_level", 64'(key_level), 64'h0);
    run(1);
    chk("post_rst_press_level", 64'(key_level), 64'h10);
    keys[4] = 1'b1;
    push_ev(cyc + 6, 7'h00, 7'h10, 7'h00, 7'h00);
    run(8);

    // drain and confirm every expected pulse was seen
    run(20);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    chk("final_level", 64'(key_level), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
